// File: rtl/regfile_writeback.sv
// Writeback stage: arbitrates ALU and load results onto the register-file write port
// and keeps a load scoreboard for decode stalls. Optional bypass flags under WB_BYPASS_EN.
module regfile_writeback #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [RW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [RW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            iss_valid,
    input  logic [RW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic [RW-1:0]   rsel1,
    input  logic [RW-1:0]   rsel2,
    output logic            busy1,
    output logic            busy2,
    output logic            wen,
    output logic [RW-1:0]   wsel,
    output logic [XLEN-1:0] wdat,
    output logic            byp1,
    output logic            byp2
);

    logic            last_grant_q, last_grant_d;
    logic            wen_q, wen_d;
    logic [RW-1:0]   wsel_q, wsel_d;
    logic [XLEN-1:0] wdat_q, wdat_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic alu_go;
    logic ld_go;
    logic iss_set;

    // last_grant_q == 1 means the load unit won the previous transfer
    assign alu_go = alu_valid && (!ld_valid || last_grant_q);
    assign ld_go  = ld_valid && (!alu_valid || !last_grant_q);

    assign alu_ready = alu_go;
    assign ld_ready  = ld_go;

    always_comb begin
        last_grant_d = last_grant_q;
        if (ld_go) begin
            last_grant_d = 1'b1;
        end else if (alu_go) begin
            last_grant_d = 1'b0;
        end
    end

    // x0 writes are consumed but never reach the port; wsel/wdat only move on a real write
    always_comb begin
        wen_d  = 1'b0;
        wsel_d = wsel_q;
        wdat_d = wdat_q;
        if (ld_go) begin
            if (ld_rd != '0) begin
                wen_d  = 1'b1;
                wsel_d = ld_rd;
                wdat_d = ld_data;
            end
        end else if (alu_go) begin
            if (alu_rd != '0) begin
                wen_d  = 1'b1;
                wsel_d = alu_rd;
                wdat_d = alu_data;
            end
        end
    end

    assign iss_ready = !busy_q[iss_rd];
    assign iss_set   = iss_valid && iss_ready && (iss_rd != '0);
    assign busy1     = busy_q[rsel1];
    assign busy2     = busy_q[rsel2];

    assign busy_d[0] = 1'b0;

    // Per-register scoreboard bit: a same-cycle issue overrides a retiring load
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_sb
            logic hit_clr;
            logic hit_set;
            assign hit_clr    = ld_go && (ld_rd == RW'(gi));
            assign hit_set    = iss_set && (iss_rd == RW'(gi));
            assign busy_d[gi] = hit_set || (busy_q[gi] && !hit_clr);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            last_grant_q <= 1'b0;
            wen_q        <= 1'b0;
            wsel_q       <= '0;
            wdat_q       <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            wsel_q       <= wsel_d;
            wdat_q       <= wdat_d;
            busy_q       <= busy_d;
        end
    end

    assign wen  = wen_q;
    assign wsel = wsel_q;
    assign wdat = wdat_q;

`ifdef WB_BYPASS_EN
    assign byp1 = wen_q && (wsel_q == rsel1) && (rsel1 != '0);
    assign byp2 = wen_q && (wsel_q == rsel2) && (rsel2 != '0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, arbitration, scoreboard, x0 and bypass flags.
module tb_regfile_writeback;

    logic        clk;
    logic        n_rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  rsel1;
    logic [4:0]  rsel2;
    logic        busy1;
    logic        busy2;
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        byp1;
    logic        byp2;

    int errors = 0;
    int checks = 0;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    regfile_writeback dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rsel1     (rsel1),
        .rsel2     (rsel2),
        .busy1     (busy1),
        .busy2     (busy2),
        .wen       (wen),
        .wsel      (wsel),
        .wdat      (wdat),
        .byp1      (byp1),
        .byp2      (byp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_ld;
        n_rst     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd4;
        alu_data  = 32'h55;
        ld_valid  = 1'b0;
        ld_rd     = 5'd0;
        ld_data   = 32'h0;
        iss_valid = 1'b0;
        iss_rd    = 5'd0;
        rsel1     = 5'd7;
        rsel2     = 5'd5;

        // Reset held with an ALU result presented
        tick();
        tick();
        chk("rst_wen", wen, 0);
        chk("rst_wsel", wsel, 0);
        chk("rst_wdat", wdat, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_byp1", byp1, 0);

        n_rst = 1'b1;
        #1;
        chk("solo_alu_ready", alu_ready, 1);
        chk("solo_ld_ready", ld_ready, 0);
        tick();
        alu_valid = 1'b0;
        chk("solo_wen", wen, 1);
        chk("solo_wsel", wsel, 4);
        chk("solo_wdat", wdat, 32'h55);

        // Fresh reset, then both sources valid for four cycles
        n_rst = 1'b0;
        tick();
        chk("rst2_wen", wen, 0);
        n_rst     = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'hA;
        ld_valid  = 1'b1;
        ld_rd     = 5'd5;
        ld_data   = 32'hB;
        for (int i = 0; i < 4; i++) begin
            exp_ld = (i % 2 == 0);
            #1;
            chk($sformatf("arb%0d_ld_ready", i), ld_ready, exp_ld);
            chk($sformatf("arb%0d_alu_ready", i), alu_ready, !exp_ld);
            tick();
            chk($sformatf("arb%0d_wen", i), wen, 1);
            chk($sformatf("arb%0d_wsel", i), wsel, exp_ld ? 5 : 3);
            chk($sformatf("arb%0d_wdat", i), wdat, exp_ld ? 32'hB : 32'hA);
        end
        alu_valid = 1'b0;
        ld_valid  = 1'b0;

        // Issue a load to x7
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        #1;
        chk("iss7_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        rsel1     = 5'd7;
        #1;
        chk("idle_wen", wen, 0);
        chk("iss7_busy1", busy1, 1);
        chk("iss7_stall", iss_ready, 0);

        // Load to x7 retires
        ld_valid = 1'b1;
        ld_rd    = 5'd7;
        ld_data  = 32'h1234;
        #1;
        chk("ld7_ready", ld_ready, 1);
        chk("ld7_busy_same_cycle", busy1, 1);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("ld7_busy_clr", busy1, 0);
        chk("ld7_wen", wen, 1);
        chk("ld7_wsel", wsel, 7);
        chk("ld7_wdat", wdat, 32'h1234);

        // Issue and retire to x7 in the same cycle: set wins
        ld_valid  = 1'b1;
        ld_rd     = 5'd7;
        ld_data   = 32'h77;
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        rsel2     = 5'd7;
        #1;
        chk("sw_iss_ready", iss_ready, 1);
        chk("sw_ld_ready", ld_ready, 1);
        tick();
        ld_valid  = 1'b0;
        iss_valid = 1'b0;
        #1;
        chk("sw_busy1", busy1, 1);
        chk("sw_busy2", busy2, 1);
        chk("sw_stall", iss_ready, 0);

        ld_valid = 1'b1;
        ld_data  = 32'h88;
        tick();
        ld_valid = 1'b0;
        #1;
        chk("sw_clear", busy1, 0);

        // ALU write to x0 and issue to x0
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'hFFFF_FFFF;
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        #1;
        chk("x0_alu_ready", alu_ready, 1);
        chk("x0_iss_ready", iss_ready, 1);
        tick();
        alu_valid = 1'b0;
        iss_valid = 1'b0;
        rsel1     = 5'd0;
        #1;
        chk("x0_wen", wen, 0);
        chk("x0_busy1", busy1, 0);
        chk("x0_iss_ready_after", iss_ready, 1);

        // Bypass flags on a pending write to x9
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h99;
        tick();
        alu_valid = 1'b0;
        rsel1     = 5'd9;
        rsel2     = 5'd3;
        #1;
        chk("byp_wen", wen, 1);
        chk("byp_wsel", wsel, 9);
        chk("byp_wdat", wdat, 32'h99);
        chk("byp1_hit", byp1, BYP);
        chk("byp2_miss", byp2, 0);
        rsel1 = 5'd0;
        rsel2 = 5'd9;
        #1;
        chk("byp1_x0", byp1, 0);
        chk("byp2_hit", byp2, BYP);
        tick();
        chk("byp_idle_wen", wen, 0);
        chk("byp_idle_byp2", byp2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writeback stage that drives the register-file write port (wen/wsel/wdat) from two result sources: the single-cycle ALU and a variable-latency load unit.
- Arbitrates between the sources with alternating priority and registers the winning write.
- Keeps a load scoreboard so decode can stall on registers whose load is still outstanding.

Parameters:
- XLEN, 32, data width of the write port and results
- NREG, 32, number of architectural registers; the register-select width is $clog2(NREG)

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result available
- ld_ready  out  1  load result accepted this cycle
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load result
- iss_valid  in  1  decode issues a load this cycle
- iss_rd  in  5  destination register of the issued load
- iss_ready  out  1  issue allowed (destination not busy)
- rsel1, rsel2  in  5  decode source registers to check
- busy1, busy2  out  1  the matching source has an outstanding load
- wen  out  1  register-file write enable
- wsel  out  5  register-file write select
- wdat  out  XLEN  register-file write data
- byp1, byp2  out  1  bypass hit for rsel1/rsel2 (WB_BYPASS_EN only)

Behaviour:
- Reset: all signals are sampled on posedge clk with n_rst==0. The following are cleared to 0:
  - wen, wsel, wdat
  - all scoreboard busy bits
  - the priority toggle (last_grant = ALU)
  - byp1, byp2
- Reset mid-operation discards any unretired result; sources must re-present after reset.
- Handshake: a transfer occurs on a cycle where valid && ready. ready is combinational from the valids and last_grant. ready never depends on data.
- Arbitration when only one source is valid: that source's ready=1.
- Arbitration when both are valid: the source not granted last time wins, the loser's ready=0, and last_grant updates to the winner.
- When neither source is valid, last_grant holds.
- Latency: an accepted result appears on wen/wsel/wdat at the next posedge, exactly 1 cycle. With no accept, wen=0 the next cycle; wsel/wdat hold their values.
- x0: an accepted result with rd==0 is consumed (ready=1) but produces wen=0 and does not touch the scoreboard.
- Throughput: one write per cycle; no internal buffering beyond the output register.
- Scoreboard: NREG busy bits; bit 0 is always 0.
  - Set: iss_valid && iss_ready && iss_rd!=0 sets busy[iss_rd].
  - Clear: an accepted load clears busy[ld_rd].
  - Set and clear of the same register in the same cycle: set wins.
- iss_ready = !busy[iss_rd], combinational. An issue to x0 is always ready.
- busy1 = busy[rsel1] and busy2 = busy[rsel2], combinational from the current state. They do not see a clear happening this cycle.
- ALU results are not scoreboarded; in-order decode guarantees no ALU/load WAW to the same rd while busy.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: byp1 = wen && wsel==rsel1 && rsel1!=0 (likewise byp2), combinational. Decode muxes wdat over the register-file read data, covering the cycle where the register file has not yet captured the write.
- Undefined: byp1 and byp2 are tied to 0, and no comparators are built.

Test Plan:
- Reset with alu_valid=1 held → wen=0 and scoreboard clear during reset. First cycle after n_rst=1: ALU is accepted. Next cycle: wen=1, wsel and wdat equal the presented values.
- Both sources valid for 4 cycles (alu_rd=3/0xA, ld_rd=5/0xB) starting from reset → grants go load, ALU, load, ALU. wsel sequence 5,3,5,3, one per cycle, with the loser's ready=0 each cycle.
- Issue a load to x7 → busy[7]=1, and iss_ready=0 for iss_rd=7. Load accepted with ld_rd=7/0x1234 → busy cleared next cycle; wsel=7, wdat=0x1234.
- Same cycle: iss_rd=7 issued while the load to x7 is accepted → busy[7] stays 1 (set wins).
- ALU result to rd=0 with data 0xFFFF_FFFF → alu_ready=1, wen=0 the next cycle, and no busy bit is set.
- WB_BYPASS_EN defined, write to x9 pending on wen, rsel1=9 → byp1=1 and byp2=0. Undefined → both 0.
